note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
Initiator side of the note-duration interface. Fetches note words from a synchronous pattern ROM and drives the duration counter's load/duration inputs, one note at a time. It presents pitch and gate to the tone generator for each note, and advances to the next note on the counter's done pulse. Handles end-of-pattern markers, looping, and start/stop control from the register block.

Parameters:
ADDR_WIDTH, 8, pattern ROM address width.
PITCH_WIDTH, 6, pitch index width; pitch 0 means rest.
DUR_WIDTH, 5, duration field width; must match the duration counter.

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_enable  input  1  tick strobe, shared with the duration counter
i_start  input  1  pulse: begin playback at i_start_addr
i_stop  input  1  pulse: abort playback
i_loop  input  1  level: on end marker, restart at i_start_addr
i_start_addr  input  ADDR_WIDTH  pattern start address
o_rom_addr  output  ADDR_WIDTH  ROM read address
o_rom_rd  output  1  ROM read strobe
i_rom_data  input  1+PITCH_WIDTH+DUR_WIDTH  ROM word, valid the cycle after o_rom_rd; layout {end, pitch, duration}
o_load  output  1  load request to the duration counter
o_duration  output  DUR_WIDTH  duration to load
i_done  input  1  duration counter done pulse
i_running  input  1  duration counter running status
o_pitch  output  PITCH_WIDTH  current pitch
o_gate  output  1  note sounding (PLAY state and pitch != 0)
o_busy  output  1  state != IDLE
o_end  output  1  one-cycle pulse when playback terminates at an end marker

Behaviour:
- Reset (async, i_rst_n=0) forces:
  - state IDLE; o_rom_addr=0.
  - all registered outputs 0: o_rom_rd, o_load, o_duration, o_pitch, o_gate, o_busy, o_end.
  - first_word flag = 0.
- States: IDLE, FETCH, WAIT_DATA, LOAD, PLAY.
- IDLE: on i_start, addr <- i_start_addr, first_word <- 1, go to FETCH.
- FETCH: assert o_rom_rd for exactly one cycle with o_rom_addr, then go to WAIT_DATA.
- WAIT_DATA: capture i_rom_data.
  - end=1, first_word=1: empty pattern. Pulse o_end, go to IDLE regardless of i_loop.
  - end=1, first_word=0, i_loop=1: addr <- i_start_addr, first_word <- 1, go to FETCH.
  - end=1, first_word=0, i_loop=0: pulse o_end, go to IDLE.
  - otherwise: latch pitch and duration, first_word <- 0, go to LOAD.
- LOAD: hold o_load=1 and o_duration.
  - Stay in LOAD until a cycle with i_enable=1 and i_running=0; that is the acceptance cycle.
  - On acceptance go to PLAY. o_load drops the following cycle.
- PLAY:
  - o_pitch holds the note pitch; o_gate=(pitch!=0).
  - On i_done: addr <- addr+1, wrapping modulo 2^ADDR_WIDTH, go to FETCH.
  - A note therefore sounds for duration+1 enabled ticks after the load tick.
- Control priority: i_stop > i_start > normal sequencing.
  - i_stop in any state: next state IDLE, o_gate=0, o_load=0, no o_end. The counter runs out on its own.
  - i_start in any non-IDLE state restarts from i_start_addr (FETCH next cycle).
  - The LOAD wait on i_running guarantees no load is dropped while the previous note drains.
- o_pitch holds its last value in IDLE; o_gate is 0 outside PLAY.
- i_done outside PLAY is ignored.
- o_end and o_rom_rd never assert in the same cycle.
- Reset asserted mid-note returns everything to reset values immediately; no pulse is emitted.

Test Plan:
- ROM {p=5,d=2},{p=9,d=0},{end}; i_enable=1 every cycle; start at 0, i_loop=0 -> loads d=2 then d=0. Gate high for 4 cycles (pitch 5), then 2 cycles (pitch 9). One o_end pulse, then o_busy=0.
- Same ROM, i_loop=1, i_enable every 4th cycle -> addresses 0,1,2,0,1,2... Each load accepted only on an enable tick. o_end never asserts.
- ROM word 0 = {end}, i_loop=1 -> single fetch, o_end pulse, IDLE. No repeated fetch.
- i_stop during PLAY of a d=31 note -> o_gate=0 next cycle, IDLE. Immediate i_start -> o_load holds until i_running=0, then loads.
- Note {p=0,d=3} -> o_gate stays 0 for the full 4 ticks; sequencing advances normally.
- Start at addr 255 (ADDR_WIDTH=8), non-end word -> next fetch at addr 0. Async reset mid-PLAY -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/note_sequencer_if.sv
// Note-sequencer bus: pattern ROM read port plus the duration-counter load handshake.
//   o_rom_addr  ROM read address              (sequencer -> ROM)
//   o_rom_rd    ROM read strobe               (sequencer -> ROM)
//   i_rom_data  ROM word {end, pitch, dur}    (ROM -> sequencer), valid the cycle after o_rom_rd
//   o_load      load request                  (sequencer -> counter)
//   o_duration  duration to load              (sequencer -> counter)
//   i_done      counter done pulse            (counter -> sequencer)
//   i_running   counter running status        (counter -> sequencer)
interface note_sequencer_if #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned PITCH_WIDTH = 6,
    parameter int unsigned DUR_WIDTH   = 5
);
    logic [ADDR_WIDTH-1:0]                o_rom_addr;
    logic                                 o_rom_rd;
    logic [PITCH_WIDTH+DUR_WIDTH:0]       i_rom_data;
    logic                                 o_load;
    logic [DUR_WIDTH-1:0]                 o_duration;
    logic                                 i_done;
    logic                                 i_running;

    modport master (
        output o_rom_addr, o_rom_rd, o_load, o_duration,
        input  i_rom_data, i_done, i_running
    );

    modport slave (
        input  o_rom_addr, o_rom_rd, o_load, o_duration,
        output i_rom_data, i_done, i_running
    );
endinterface

// File: rtl/note_sequencer.sv
// Note sequencer: walks a pattern ROM one note at a time, hands each duration to the
// duration counter and presents pitch/gate to the tone generator until the counter
// reports done. Handles end markers, looping and start/stop control.
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_enable         tick strobe shared with the duration counter
//   i_start/i_stop   control pulses (stop wins over start)
//   i_loop           restart at i_start_addr when an end marker is reached
//   i_start_addr     pattern start address
//   o_pitch/o_gate   current pitch, note sounding
//   o_busy           sequencer not idle
//   o_end            one-cycle pulse when playback ends at an end marker
//   bus              ROM read port and duration-counter handshake
module note_sequencer #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned PITCH_WIDTH = 6,
    parameter int unsigned DUR_WIDTH   = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic                   i_loop,
    input  logic [ADDR_WIDTH-1:0]  i_start_addr,
    output logic [PITCH_WIDTH-1:0] o_pitch,
    output logic                   o_gate,
    output logic                   o_busy,
    output logic                   o_end,
    note_sequencer_if.master       bus
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWaitData,
        StLoad,
        StPlay
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   first_q, first_d;
    logic [PITCH_WIDTH-1:0] pitch_q, pitch_d;
    logic [DUR_WIDTH-1:0]   dur_q, dur_d;
    logic                   end_q, end_d;

    logic                   rom_end;
    logic [PITCH_WIDTH-1:0] rom_pitch;
    logic [DUR_WIDTH-1:0]   rom_dur;

    assign rom_end   = bus.i_rom_data[PITCH_WIDTH+DUR_WIDTH];
    assign rom_pitch = bus.i_rom_data[DUR_WIDTH +: PITCH_WIDTH];
    assign rom_dur   = bus.i_rom_data[0 +: DUR_WIDTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            first_q <= 1'b0;
            pitch_q <= '0;
            dur_q   <= '0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            first_q <= first_d;
            pitch_q <= pitch_d;
            dur_q   <= dur_d;
            end_q   <= end_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        first_d = first_q;
        pitch_d = pitch_q;
        dur_d   = dur_q;
        end_d   = 1'b0;

        if (i_stop) begin
            // The counter is left to run out; the next load waits on i_running.
            state_d = StIdle;
        end else if (i_start) begin
            addr_d  = i_start_addr;
            first_d = 1'b1;
            state_d = StFetch;
        end else begin
            unique case (state_q)
                StIdle: ;
                StFetch: state_d = StWaitData;
                StWaitData: begin
                    if (rom_end) begin
                        // An end marker as the first word is an empty pattern: never loop on it.
                        if (first_q || !i_loop) begin
                            end_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            addr_d  = i_start_addr;
                            first_d = 1'b1;
                            state_d = StFetch;
                        end
                    end else begin
                        pitch_d = rom_pitch;
                        dur_d   = rom_dur;
                        first_d = 1'b0;
                        state_d = StLoad;
                    end
                end
                // The counter takes the load on an enabled tick while it is idle.
                StLoad: if (i_enable && !bus.i_running) state_d = StPlay;
                StPlay: begin
                    if (bus.i_done) begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = StFetch;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign bus.o_rom_addr = addr_q;
    assign bus.o_rom_rd   = (state_q == StFetch);
    assign bus.o_load     = (state_q == StLoad);
    assign bus.o_duration = dur_q;
    assign o_pitch        = pitch_q;
    assign o_gate         = (state_q == StPlay) && (pitch_q != '0);
    assign o_busy         = (state_q != StIdle);
    assign o_end          = end_q;

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;
    localparam int AW = 8;
    localparam int PW = 6;
    localparam int DW = 5;
    localparam int WW = 1 + PW + DW;
    localparam logic [WW-1:0] END_W = {1'b1, {(PW+DW){1'b0}}};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_enable, i_start, i_stop, i_loop;
    logic [AW-1:0] i_start_addr;
    logic [PW-1:0] o_pitch;
    logic          o_gate, o_busy, o_end;

    always #5 clk = ~clk;

    note_sequencer_if #(.ADDR_WIDTH(AW), .PITCH_WIDTH(PW), .DUR_WIDTH(DW)) bus ();

    note_sequencer #(.ADDR_WIDTH(AW), .PITCH_WIDTH(PW), .DUR_WIDTH(DW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_enable    (i_enable),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_loop      (i_loop),
        .i_start_addr(i_start_addr),
        .o_pitch     (o_pitch),
        .o_gate      (o_gate),
        .o_busy      (o_busy),
        .o_end       (o_end),
        .bus         (bus)
    );

    // Synchronous pattern ROM.
    logic [WW-1:0] mem [256];
    always @(posedge clk) begin
        if (bus.o_rom_rd) bus.i_rom_data <= mem[bus.o_rom_addr];
    end

    // Duration counter: takes a load on an enabled idle tick, then counts duration+1
    // enabled ticks and pulses done.
    logic [DW-1:0] cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.i_running <= 1'b0;
            bus.i_done    <= 1'b0;
            cnt           <= '0;
        end else begin
            bus.i_done <= 1'b0;
            if (i_enable) begin
                if (bus.i_running) begin
                    if (cnt == 0) begin
                        bus.i_running <= 1'b0;
                        bus.i_done    <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end else if (bus.o_load) begin
                    bus.i_running <= 1'b1;
                    cnt           <= bus.o_duration;
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int en_period = 1;

    // Observed activity.
    int            fetch_q[$];
    logic [10:0]   load_q[$];
    int            gate_p_q[$];
    int            gate_len_q[$];
    int            end_cnt, load_wait, viol, gate_len, gate_pitch;
    bit            gate_prev;

    // Reference results.
    int            exp_fetch[$];
    logic [10:0]   exp_loads[$];
    int            exp_end;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        i_enable = (en_period <= 1) ? 1'b1 : ((cyc % en_period) == 0);
        if (bus.o_rom_rd) fetch_q.push_back(int'(bus.o_rom_addr));
        if (bus.o_load && i_enable && !bus.i_running) load_q.push_back({o_pitch, bus.o_duration});
        if (bus.o_load && bus.i_running) load_wait++;
        if (o_end) end_cnt++;
        if ((o_end && bus.o_rom_rd) || (o_gate && !o_busy) || (o_gate && o_pitch == 0)) viol++;
        if (o_gate) begin
            if (!gate_prev) gate_len = 0;
            gate_len++;
            gate_pitch = int'(o_pitch);
        end else if (gate_prev) begin
            gate_p_q.push_back(gate_pitch);
            gate_len_q.push_back(gate_len);
        end
        gate_prev = o_gate;
    endtask

    task automatic clear_mon();
        fetch_q.delete();
        load_q.delete();
        gate_p_q.delete();
        gate_len_q.delete();
        end_cnt = 0; load_wait = 0; viol = 0; gate_len = 0; gate_pitch = 0; gate_prev = 1'b0;
    endtask

    task automatic do_reset();
        i_start = 0; i_stop = 0; i_loop = 0; i_start_addr = '0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        clear_mon();
    endtask

    task automatic pulse_start(input int addr);
        i_start_addr = AW'(addr);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic run_to_idle(input string tag, input int budget);
        for (int i = 0; i < budget && o_busy; i++) step();
        chk({tag, "_idle"}, o_busy, 0);
        step(); step();
    endtask

    task automatic wait_gate(input string tag, input int budget);
        for (int i = 0; i < budget && !o_gate; i++) step();
        chk({tag, "_gate_on"}, o_gate, 1);
    endtask

    function automatic logic [WW-1:0] note(input int p, input int d);
        logic [WW-1:0] w;
        w = {1'b0, PW'(p), DW'(d)};
        return w;
    endfunction

    // Walks the pattern by its rules: notes advance the address, end markers stop or loop.
    task automatic ref_walk(input int start, input bit loop, input int max_fetch);
        int addr;
        bit first;
        logic [WW-1:0] w;
        exp_fetch.delete();
        exp_loads.delete();
        exp_end = 0;
        addr = start;
        first = 1;
        while (exp_fetch.size() < max_fetch) begin
            exp_fetch.push_back(addr);
            w = mem[addr];
            if (w[WW-1]) begin
                if (first || !loop) begin
                    exp_end = 1;
                    break;
                end
                addr = start;
                first = 1;
            end else begin
                exp_loads.push_back(w[10:0]);
                first = 0;
                addr = (addr + 1) % 256;
            end
        end
    endtask

    task automatic compare_run(input string tag, input bit chk_len);
        int k;
        chk({tag, "_nfetch"}, fetch_q.size(), exp_fetch.size());
        for (int i = 0; i < exp_fetch.size() && i < fetch_q.size(); i++)
            chk({tag, "_fetch"}, fetch_q[i], exp_fetch[i]);
        chk({tag, "_nload"}, load_q.size(), exp_loads.size());
        for (int i = 0; i < exp_loads.size() && i < load_q.size(); i++)
            chk({tag, "_load"}, load_q[i], exp_loads[i]);
        chk({tag, "_end"}, end_cnt, exp_end);
        chk({tag, "_viol"}, viol, 0);
        k = 0;
        for (int i = 0; i < exp_loads.size(); i++) begin
            if (exp_loads[i][10:5] != 0) begin
                if (k < gate_p_q.size()) begin
                    chk({tag, "_gate_pitch"}, gate_p_q[k], exp_loads[i][10:5]);
                    if (chk_len) chk({tag, "_gate_len"}, gate_len_q[k], exp_loads[i][4:0] + 2);
                end
                k++;
            end
        end
        chk({tag, "_ngate"}, gate_p_q.size(), k);
    endtask

    task automatic fill_end();
        for (int i = 0; i < 256; i++) mem[i] = END_W;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rom_addr"}, bus.o_rom_addr, 0);
        chk({tag, "_rom_rd"}, bus.o_rom_rd, 0);
        chk({tag, "_load"}, bus.o_load, 0);
        chk({tag, "_duration"}, bus.o_duration, 0);
        chk({tag, "_pitch"}, o_pitch, 0);
        chk({tag, "_gate"}, o_gate, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_end"}, o_end, 0);
    endtask

    initial begin
        i_enable = 1'b1;
        fill_end();
        do_reset();
        rst_n = 1'b0;
        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Two notes then an end marker, enable every cycle.
        do_reset();
        en_period = 1;
        mem[0] = note(5, 2); mem[1] = note(9, 0); mem[2] = END_W;
        ref_walk(0, 0, 64);
        pulse_start(0);
        run_to_idle("basic", 200);
        compare_run("basic", 1);

        // Looping with a sparse enable.
        do_reset();
        en_period = 4;
        i_loop = 1'b1;
        ref_walk(0, 1, 9);
        pulse_start(0);
        for (int i = 0; i < 2000 && fetch_q.size() < 9; i++) step();
        i_stop = 1'b1; step(); i_stop = 1'b0;
        chk("loop_nfetch", fetch_q.size() >= 9, 1);
        for (int i = 0; i < 9 && i < fetch_q.size(); i++) chk("loop_fetch", fetch_q[i], exp_fetch[i]);
        for (int i = 0; i < 5 && i < load_q.size(); i++) chk("loop_load", load_q[i], exp_loads[i]);
        chk("loop_nload", load_q.size() >= 5, 1);
        chk("loop_end", end_cnt, 0);
        chk("loop_viol", viol, 0);
        i_loop = 1'b0;

        // Empty pattern with looping enabled: one fetch, one end pulse.
        do_reset();
        en_period = 1;
        fill_end();
        i_loop = 1'b1;
        ref_walk(0, 1, 64);
        pulse_start(0);
        run_to_idle("empty", 50);
        step(); step(); step();
        compare_run("empty", 1);
        i_loop = 1'b0;

        // Stop during a long note, then restart while the counter drains.
        do_reset();
        mem[10] = note(7, 31); mem[11] = note(3, 1); mem[12] = END_W;
        pulse_start(10);
        wait_gate("stop", 50);
        for (int i = 0; i < 5; i++) step();
        i_stop = 1'b1; step(); i_stop = 1'b0;
        chk("stop_gate_off", o_gate, 0);
        chk("stop_busy", o_busy, 0);
        chk("stop_no_end", o_end, 0);
        clear_mon();
        ref_walk(10, 0, 64);
        pulse_start(10);
        for (int i = 0; i < 100 && load_q.size() == 0; i++) step();
        chk("restart_load_held", load_wait > 0, 1);
        run_to_idle("restart", 300);
        compare_run("restart", 1);

        // Rest note keeps gate low but still sequences.
        do_reset();
        mem[20] = note(0, 3); mem[21] = note(4, 1); mem[22] = END_W;
        ref_walk(20, 0, 64);
        pulse_start(20);
        run_to_idle("rest", 200);
        compare_run("rest", 1);

        // Address wraps from 255 to 0.
        do_reset();
        fill_end();
        mem[255] = note(12, 2);
        ref_walk(255, 0, 64);
        pulse_start(255);
        run_to_idle("wrap", 200);
        compare_run("wrap", 1);

        // Asynchronous reset in the middle of a note.
        do_reset();
        mem[40] = note(6, 10); mem[41] = END_W;
        pulse_start(40);
        wait_gate("areset", 50);
        step(); step();
        rst_n = 1'b0;
        #1;
        check_all_zero("areset");
        step();
        rst_n = 1'b1;

        // Randomized patterns.
        for (int it = 0; it < 8; it++) begin
            int start;
            do_reset();
            for (int i = 0; i < 256; i++) begin
                if ($urandom_range(0, 5) == 0) mem[i] = END_W;
                else if ($urandom_range(0, 4) == 0) mem[i] = note(0, $urandom_range(0, 12));
                else mem[i] = note($urandom_range(1, 63), $urandom_range(0, 12));
            end
            start = $urandom_range(0, 255);
            mem[(start + 6) % 256] = END_W;
            en_period = $urandom_range(1, 3);
            ref_walk(start, 0, 64);
            pulse_start(start);
            run_to_idle("rand", 1500);
            compare_run("rand", en_period == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
